adder: RTL and testbench
========================

ADDER -- requirements
Module: adder

Interface
REQ-001 Parameter: WIDTH, default 16, operand and result width in bits.
REQ-002 Parameter: PIPE, default 1, number of output register stages (legal values 1 or 2).
REQ-003 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-004 Port: rst_n  input  1  reset, synchronous and active-low.
REQ-005 Port: in_valid  input  1  operands and op are valid this cycle.
REQ-006 Port: sub  input  1  0 = a+b, 1 = a-b.
REQ-007 Port: a  input  WIDTH  operand A.
REQ-008 Port: b  input  WIDTH  operand B.
REQ-009 Port: out  output  WIDTH  result, two's-complement wrap unless saturation is compiled in.
REQ-010 Port: out_valid  output  1  out and flags are valid this cycle.
REQ-011 Port: cout  output  1  unsigned carry out (add) or not-borrow (sub).
REQ-012 Port: ovf  output  1  signed overflow of the true result.
REQ-013 Port: zero  output  1  out equals 0.

Function
REQ-014 Add: out SHALL equal (a + b) mod 2^WIDTH; cout SHALL equal bit WIDTH of the full sum.
REQ-015 Subtract: out SHALL equal (a + ~b + 1) mod 2^WIDTH; cout SHALL be 1 when a >= b unsigned.
REQ-016 ovf SHALL be 1 when both effective operands share a sign and the result sign differs.
REQ-017 Latency SHALL be exactly PIPE cycles from in_valid to out_valid, with throughput of one operation per cycle and no backpressure.
REQ-018 When in_valid is 0, out_valid SHALL be 0 PIPE cycles later; out and flags SHALL hold their last valid values.
REQ-019 Wrap-around: 0xFFFF + 0x0001 SHALL give out 0x0000, cout 1, zero 1, ovf 0.
REQ-020 The design SHALL have no combinational path from any input to any output.

Reset
REQ-021 While rst_n is low at a rising clk edge, out SHALL become 0, out_valid 0, cout 0, ovf 0, and zero 1.
REQ-022 Reset SHALL discard in-flight operations in every pipeline stage; out_valid SHALL remain 0 until PIPE cycles after the first accepted in_valid following reset release.

Configuration
REQ-023 Macro ADDER_SAT_EN: when defined, signed overflow SHALL clamp out to 0x7FFF (positive) or 0x8000 (negative) for WIDTH 16; ovf still reports the overflow, and cout is unchanged.
REQ-024 Without ADDER_SAT_EN, out SHALL wrap modulo 2^WIDTH and no clamp logic SHALL be present.

Structure
REQ-025 Shared package adder_pkg SHALL hold the WIDTH default, the op encoding constants (OP_ADD=0, OP_SUB=1), and the saturation limit constants.
REQ-026 Carry logic SHALL be built from a sub-module cla4 (4-bit carry-lookahead slice with group propagate/generate), instantiated WIDTH/4 times; WIDTH SHALL be a multiple of 4.

Verification
REQ-027 Hold reset low for 10 cycles, then release with in_valid=0 -> out=0x0000, out_valid=0, zero=1 throughout.
REQ-028 a=0x0001, b=0x0003, sub=0, in_valid=1 -> after PIPE cycles, out=0x0004, cout=0, ovf=0, zero=0, out_valid=1.
REQ-029 a=0xFFFF, b=0x0001, add -> out=0x0000, cout=1, zero=1, ovf=0.
REQ-030 a=0x7FFF, b=0x0001, add -> ovf=1; out=0x8000 without ADDER_SAT_EN, out=0x7FFF with it.
REQ-031 a=0x0003, b=0x0005, sub=1 -> out=0xFFFE, cout=0, ovf=0.
REQ-032 Apply a back-to-back stream of 100 random operations, then assert rst_n low mid-stream -> every result matches the reference model, and out_valid drops on the next edge after reset.

Source files
------------

// File: rtl/adder_pkg.sv
// Shared constants for the pipelined adder/subtractor: default width, op encoding
// and 16-bit saturation limits.
package adder_pkg;

  localparam int WIDTH_DEF = 16;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  // Clamp values used when saturation is built in (ADDER_SAT_EN) at the default width.
  localparam logic [15:0] SAT_POS_16 = 16'h7FFF;
  localparam logic [15:0] SAT_NEG_16 = 16'h8000;

endpackage

// File: rtl/adder_cla4.sv
// 4-bit carry-lookahead slice: local sum plus group propagate/generate for chaining.
module cla4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       gp,
  output logic       gg
);

  logic [3:0] p;
  logic [3:0] g;
  logic [3:0] c;

  assign p = a ^ b;
  assign g = a & b;

  assign c[0] = cin;
  assign c[1] = g[0] | (p[0] & cin);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);

  assign sum = p ^ c;
  assign gp  = &p;
  assign gg  = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);

endmodule

// File: rtl/adder.sv
// Pipelined add/subtract with carry, signed overflow and zero flags; PIPE output stages.
// Optional clamp-on-overflow is compiled in with the ADDER_SAT_EN macro.
module adder
  import adder_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int PIPE  = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] out,
  output logic             out_valid,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int NSLICE = WIDTH / 4;
  localparam int MSB    = WIDTH - 1;

  logic [WIDTH-1:0]  b_eff;
  logic [WIDTH-1:0]  sum;
  logic [NSLICE:0]   carry;
  logic [NSLICE-1:0] gp;
  logic [NSLICE-1:0] gg;
  logic [WIDTH-1:0]  result_c;
  logic              ovf_c;
  logic              zero_c;

  // Subtraction is a + ~b + 1: invert b and inject the +1 as the carry-in.
  assign b_eff    = (sub == OP_ADD) ? b : ~b;
  assign carry[0] = (sub == OP_SUB);

  for (genvar i = 0; i < NSLICE; i++) begin : g_slice
    cla4 u_cla4 (
      .a   (a[4*i +: 4]),
      .b   (b_eff[4*i +: 4]),
      .cin (carry[i]),
      .sum (sum[4*i +: 4]),
      .gp  (gp[i]),
      .gg  (gg[i])
    );
    assign carry[i+1] = gg[i] | (gp[i] & carry[i]);
  end

  assign ovf_c = (a[MSB] == b_eff[MSB]) && (sum[MSB] != a[MSB]);

`ifdef ADDER_SAT_EN
  localparam logic [WIDTH-1:0] SAT_POS = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SAT_NEG = {1'b1, {(WIDTH-1){1'b0}}};
  // Overflow direction follows the common operand sign.
  assign result_c = ovf_c ? (a[MSB] ? SAT_NEG : SAT_POS) : sum;
`else
  assign result_c = sum;
`endif

  assign zero_c = (result_c == '0);

  // Stage 1: data registers only load on accepted operations so idle cycles hold.
  logic             v1;
  logic [WIDTH-1:0] o1;
  logic             c1;
  logic             ov1;
  logic             z1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v1  <= 1'b0;
      o1  <= '0;
      c1  <= 1'b0;
      ov1 <= 1'b0;
      z1  <= 1'b1;
    end else begin
      v1 <= in_valid;
      if (in_valid) begin
        o1  <= result_c;
        c1  <= carry[NSLICE];
        ov1 <= ovf_c;
        z1  <= zero_c;
      end
    end
  end

  if (PIPE == 2) begin : g_pipe2
    logic             v2;
    logic [WIDTH-1:0] o2;
    logic             c2;
    logic             ov2;
    logic             z2;

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        v2  <= 1'b0;
        o2  <= '0;
        c2  <= 1'b0;
        ov2 <= 1'b0;
        z2  <= 1'b1;
      end else begin
        v2 <= v1;
        if (v1) begin
          o2  <= o1;
          c2  <= c1;
          ov2 <= ov1;
          z2  <= z1;
        end
      end
    end

    assign out_valid = v2;
    assign out       = o2;
    assign cout      = c2;
    assign ovf       = ov2;
    assign zero      = z2;
  end else begin : g_pipe1
    assign out_valid = v1;
    assign out       = o1;
    assign cout      = c1;
    assign ovf       = ov1;
    assign zero      = z1;
  end

endmodule

// File: tb/tb_adder.sv
// Directed plus random check of the adder against a signed/unsigned integer reference,
// with an expected-result queue and held-output checks on idle cycles.
module tb_adder;

  localparam int W    = 16;
  localparam int PIPE = 1;
  localparam int EW   = W + 3;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         sub;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [W-1:0] out;
  logic         out_valid;
  logic         cout;
  logic         ovf;
  logic         zero;

  int errors = 0;
  int checks = 0;

  logic [EW-1:0]   exp_q[$];
  logic [EW-1:0]   last_exp;
  logic [PIPE-1:0] vpipe;

  adder #(.WIDTH(W), .PIPE(PIPE)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .sub       (sub),
    .a         (a),
    .b         (b),
    .out       (out),
    .out_valid (out_valid),
    .cout      (cout),
    .ovf       (ovf),
    .zero      (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference built from integer arithmetic; packed as {out, cout, ovf, zero}.
  function automatic logic [EW-1:0] model(input logic s, input logic [W-1:0] x, input logic [W-1:0] y);
    int           ux, uy, sx, sy, tr;
    logic [W-1:0] r;
    logic         c, v;
    ux = int'(x);
    uy = int'(y);
    sx = int'($signed(x));
    sy = int'($signed(y));
    if (s) begin
      tr = sx - sy;
      c  = (ux >= uy);
      r  = W'(ux - uy);
    end else begin
      tr = sx + sy;
      c  = ((ux + uy) > 65535);
      r  = W'(ux + uy);
    end
    v = (tr > 32767) || (tr < -32768);
`ifdef ADDER_SAT_EN
    if (v) r = (tr > 0) ? 16'h7FFF : 16'h8000;
`endif
    return {r, c, v, (r == '0)};
  endfunction

  // One clock: update the bench-side pipeline, then check outputs #1 after the edge.
  task automatic tick();
    @(posedge clk);
    if (!rst_n) begin
      vpipe = '0;
      exp_q.delete();
      last_exp = {{W{1'b0}}, 1'b0, 1'b0, 1'b1};
    end else begin
      if (in_valid) exp_q.push_back(model(sub, a, b));
      for (int i = PIPE - 1; i > 0; i--) vpipe[i] = vpipe[i-1];
      vpipe[0] = in_valid;
    end
    #1;
    chk("out_valid", {31'd0, out_valid}, {31'd0, vpipe[PIPE-1]});
    if (vpipe[PIPE-1]) begin
      if (exp_q.size() == 0) chk("queue_underflow", 32'd1, 32'd0);
      else last_exp = exp_q.pop_front();
    end
    chk("out",  {16'd0, out},          {16'd0, last_exp[EW-1:3]});
    chk("cout", {31'd0, cout},         {31'd0, last_exp[2]});
    chk("ovf",  {31'd0, ovf},          {31'd0, last_exp[1]});
    chk("zero", {31'd0, zero},         {31'd0, last_exp[0]});
  endtask

  task automatic op(input logic s, input logic [W-1:0] x, input logic [W-1:0] y);
    in_valid = 1'b1;
    sub      = s;
    a        = x;
    b        = y;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic expect_now(input string tag, input logic [W-1:0] eo, input logic ec,
                            input logic ev, input logic ez);
    repeat (PIPE - 1) tick();
    chk({tag, "_valid"}, {31'd0, out_valid}, {31'd0, (PIPE == 1)});
    chk({tag, "_out"},   {16'd0, out},       {16'd0, eo});
    chk({tag, "_cout"},  {31'd0, cout},      {31'd0, ec});
    chk({tag, "_ovf"},   {31'd0, ovf},       {31'd0, ev});
    chk({tag, "_zero"},  {31'd0, zero},      {31'd0, ez});
  endtask

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b0;
    sub      = 1'b0;
    a        = '0;
    b        = '0;
    vpipe    = '0;
    last_exp = {{W{1'b0}}, 1'b0, 1'b0, 1'b1};

    repeat (10) tick();
    rst_n = 1'b1;
    repeat (3) tick();

    op(1'b0, 16'h0001, 16'h0003);
    expect_now("add_1_3", 16'h0004, 1'b0, 1'b0, 1'b0);
    op(1'b0, 16'hFFFF, 16'h0001);
    expect_now("wrap", 16'h0000, 1'b1, 1'b1 ^ 1'b1, 1'b1);
    op(1'b0, 16'h7FFF, 16'h0001);
`ifdef ADDER_SAT_EN
    expect_now("pos_ovf", 16'h7FFF, 1'b0, 1'b1, 1'b0);
`else
    expect_now("pos_ovf", 16'h8000, 1'b0, 1'b1, 1'b0);
`endif
    op(1'b1, 16'h0003, 16'h0005);
    expect_now("sub_3_5", 16'hFFFE, 1'b0, 1'b0, 1'b0);
    op(1'b1, 16'h1234, 16'h1234);
    expect_now("sub_eq", 16'h0000, 1'b1, 1'b0, 1'b1);

    // Idle cycles: outputs must hold the last result.
    repeat (3) tick();

    for (int i = 0; i < 100; i++)
      op(1'($urandom_range(0, 1)), W'($urandom_range(0, 65535)), W'($urandom_range(0, 65535)));

    // Reset lands mid-stream with an operation still presented.
    in_valid = 1'b1;
    sub      = 1'b0;
    a        = 16'h0101;
    b        = 16'h0202;
    rst_n    = 1'b0;
    tick();
    chk("rst_mid_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_mid_zero",  {31'd0, zero},      32'd1);
    in_valid = 1'b0;
    rst_n    = 1'b1;
    repeat (3) tick();

    op(1'b1, 16'h8000, 16'h0001);
    repeat (PIPE) tick();
    op(1'b1, 16'h0000, 16'h8000);
    repeat (PIPE + 2) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
